// File: rtl/alusys_trace_capture_if.sv
// alusys_trace_capture_if
//   Bus bundle between the ALU system datapath taps, the trace capture
//   block and the consumer that drains captured records.
//   Sample side : Smp_Valid, ALU_Out[7:0], ALU_FlagOut[3:0] {Z,C,N,O},
//                 ARF_OutB[7:0], MemOut[7:0], IR_Out[15:0]
//   Read side   : Rd_Valid, Rd_Ready, Rd_Data[43:0]
//   Modports    : slave  = the capture block (consumes samples, drives reads)
//                 master = the environment (drives samples, accepts reads)
interface alusys_trace_capture_if;
   logic        Smp_Valid;
   logic [7:0]  ALU_Out;
   logic [3:0]  ALU_FlagOut;
   logic [7:0]  ARF_OutB;
   logic [7:0]  MemOut;
   logic [15:0] IR_Out;
   logic        Rd_Ready;
   logic        Rd_Valid;
   logic [43:0] Rd_Data;

   modport slave (
      input  Smp_Valid, ALU_Out, ALU_FlagOut, ARF_OutB, MemOut, IR_Out,
      input  Rd_Ready,
      output Rd_Valid, Rd_Data
   );

   modport master (
      output Smp_Valid, ALU_Out, ALU_FlagOut, ARF_OutB, MemOut, IR_Out,
      output Rd_Ready,
      input  Rd_Valid, Rd_Data
   );
endinterface

// File: rtl/alusys_trace_capture.sv
// alusys_trace_capture
//   Response monitor for the ALU system. While a capture session is open,
//   each sample strobe records the observable datapath outputs into an
//   on-chip trace buffer; the buffer is then drained in order over a
//   valid/ready read port with first-word fall-through.
//
//   Record layout: [7:0] ALU_Out, [11:8] ALU_FlagOut, [19:12] ARF_OutB,
//                  [27:20] MemOut, [43:28] IR_Out
//
//   Ports:
//     Clock    - system clock, rising edge
//     Reset    - synchronous, active-high
//     Arm      - open a capture session (IDLE only)
//     Stop     - close the capture session (CAPTURE only)
//     bus      - sample inputs and read port (alusys_trace_capture_if.slave)
//     Count    - records currently held
//     State    - 0=IDLE, 1=CAPTURE, 2=DRAIN
//     Overflow - sticky, a sample arrived during DRAIN and was dropped
//
//   Parameters:
//     DEPTH    - trace entries, power of 2, 2..256
//
//   Optional feature macro: TRACE_CHANGE_ONLY_EN
//     When defined, a sample in CAPTURE is stored only if its record differs
//     from the last record stored this session (the first one always is).
module alusys_trace_capture #(
   parameter int unsigned DEPTH = 16
) (
   input  logic                         Clock,
   input  logic                         Reset,
   input  logic                         Arm,
   input  logic                         Stop,
   alusys_trace_capture_if.slave        bus,
   output logic [$clog2(DEPTH+1)-1:0]   Count,
   output logic [1:0]                   State,
   output logic                         Overflow
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH) + 1;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CAPTURE = 2'd1,
      ST_DRAIN   = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]     count_q, count_after_wr;
   logic              overflow_q;
   logic [43:0]       mem [DEPTH];

   logic [43:0]       rec;
   logic              clear;
   logic              wr_en;
   logic              pop;
   logic              ovf_set;
   logic              rd_valid;
   logic              sample_new;

   assign rec = {bus.IR_Out, bus.MemOut, bus.ARF_OutB, bus.ALU_FlagOut, bus.ALU_Out};

`ifdef TRACE_CHANGE_ONLY_EN
   logic [43:0] last_q;
   logic        have_last_q;

   assign sample_new = !have_last_q || (rec != last_q);

   always_ff @(posedge Clock) begin
      if (Reset) begin
         have_last_q <= 1'b0;
         last_q      <= '0;
      end else if (clear) begin
         have_last_q <= 1'b0;
      end else if (wr_en) begin
         have_last_q <= 1'b1;
         last_q      <= rec;
      end
   end
`else
   assign sample_new = 1'b1;
`endif

   assign count_after_wr = count_q + CW'(wr_en);
   assign rd_valid       = (state_q == ST_DRAIN) && (count_q != '0);

   always_comb begin
      state_d = state_q;
      clear   = 1'b0;
      wr_en   = 1'b0;
      pop     = 1'b0;
      ovf_set = 1'b0;
      case (state_q)
         ST_CAPTURE: begin
            // count_q < DEPTH always holds here; the guard just keeps the
            // buffer from ever being overrun.
            wr_en = bus.Smp_Valid && sample_new && (count_q != CW'(DEPTH));
            if (wr_en && (count_after_wr == CW'(DEPTH)))
               state_d = ST_DRAIN;
            else if (Stop)
               state_d = (count_after_wr != '0) ? ST_DRAIN : ST_IDLE;
         end
         ST_DRAIN: begin
            pop     = rd_valid && bus.Rd_Ready;
            ovf_set = bus.Smp_Valid;
            if ((pop && (count_q == CW'(1))) || (count_q == '0))
               state_d = ST_IDLE;
         end
         default: begin
            // IDLE, and the unused encoding which behaves as IDLE
            if (Arm) begin
               state_d = ST_CAPTURE;
               clear   = 1'b1;
            end else begin
               state_d = ST_IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q    <= ST_IDLE;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (clear) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
         end else begin
            if (wr_en)
               wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)
               rd_ptr_q <= rd_ptr_q + 1'b1;
            if (wr_en && !pop)
               count_q <= count_q + 1'b1;
            else if (pop && !wr_en)
               count_q <= count_q - 1'b1;
            if (ovf_set)
               overflow_q <= 1'b1;
         end
      end
   end

   // Buffer storage is never cleared; Reset only blocks a write that
   // would otherwise land in the same cycle.
   always_ff @(posedge Clock) begin
      if (wr_en && !Reset)
         mem[wr_ptr_q] <= rec;
   end

   assign bus.Rd_Valid = rd_valid;
   assign bus.Rd_Data  = mem[rd_ptr_q];
   assign Count        = count_q;
   assign State        = state_q;
   assign Overflow     = overflow_q;

endmodule

// File: doc/alusys_trace_capture.md
Name: alusys_trace_capture

Overview:
- Hardware response monitor for the ALU system. The vector-driven testbench is the stimulus side; this block is the receiving side, recording what the datapath produced.
- Samples the observable datapath outputs (ALU result, flags, memory address, memory data, IR) on a sample strobe, one per applied control vector.
- Stores samples in an on-chip trace buffer; a valid/ready read port drains it in order.
- Sits beside ALUSystem. Its strobe is the control word's Operation bit.

Parameters:
- DEPTH, 16, trace entries; power of 2, range 2..256.
- CW, $clog2(DEPTH)+1, width of Count (derived localparam, not overridable).

Ports:
- Clock  input  1  system clock, rising edge.
- Reset  input  1  synchronous, active-high reset.
- Arm  input  1  start a capture session (honoured in IDLE only).
- Stop  input  1  end the capture session (honoured in CAPTURE only).
- Smp_Valid  input  1  sample strobe.
- ALU_Out  input  8  ALU result.
- ALU_FlagOut  input  4  flags {Z,C,N,O}.
- ARF_OutB  input  8  memory address.
- MemOut  input  8  memory read data.
- IR_Out  input  16  instruction register.
- Rd_Ready  input  1  consumer accepts Rd_Data.
- Rd_Valid  output  1  Rd_Data holds an unread record.
- Rd_Data  output  44  record at the read pointer.
- Count  output  CW  records currently held.
- State  output  2  0=IDLE, 1=CAPTURE, 2=DRAIN; 3 unused, decodes to IDLE.
- Overflow  output  1  sticky: a sample was dropped.

Behaviour:
- Reset (synchronous, Clock posedge with Reset=1): State=IDLE, wr_ptr=rd_ptr=0, Count=0, Overflow=0, Rd_Valid=0. Buffer contents are not cleared. Reset overrides every other input in the same cycle, including mid-capture and mid-drain.
- Record layout: [7:0] ALU_Out, [11:8] ALU_FlagOut, [19:12] ARF_OutB, [27:20] MemOut, [43:28] IR_Out.
- IDLE:
  - Arm=1 -> CAPTURE next cycle; pointers, Count and Overflow cleared.
  - Arm and Stop together: Arm wins.
  - Smp_Valid is ignored and does not set Overflow.
- CAPTURE:
  - Smp_Valid=1 writes the record at wr_ptr on that edge. wr_ptr and Count increment; write latency is 1 cycle.
  - The write that makes Count==DEPTH moves State to DRAIN on the same edge.
  - Stop=1 -> DRAIN if the resulting Count>0, else IDLE.
  - Stop together with Smp_Valid: the sample is written first, then the transition is taken.
- DRAIN:
  - Rd_Valid = (Count!=0). Rd_Data = buffer[rd_ptr], combinational (first-word fall-through).
  - Pop occurs when Rd_Valid && Rd_Ready: rd_ptr++, Count--.
  - When the last record pops, State -> IDLE on that edge.
  - Smp_Valid=1 in DRAIN sets Overflow=1 and the sample is discarded.
  - Arm and Stop are ignored.
- Rd_Valid=0 outside DRAIN. Rd_Data is don't-care while Rd_Valid=0.
- Rd_Data must stay stable while Rd_Valid=1 and Rd_Ready=0.
- Pointers are log2(DEPTH) bits and wrap naturally modulo DEPTH.
- Count never exceeds DEPTH and never underflows.

Optional Feature:
- Macro: TRACE_CHANGE_ONLY_EN.
- Defined: in CAPTURE, a sample is written only if its 44-bit record differs from the last record written this session. The first sample after Arm is always written. Suppressed samples do not change Count and do not set Overflow.
- Undefined: every Smp_Valid sample in CAPTURE is written; no comparison register is synthesised.

Test Plan:
- Reset held 2 cycles, then released -> State=0, Count=0, Rd_Valid=0, Overflow=0.
- Arm; 3 samples with ALU_Out=0x05/0x0A/0xFF, flags 0x0/0x0/0x2, IR_Out=0x1234; Stop with Rd_Ready=1 -> State=2, Count=3. Rd_Data[7:0] reads 0x05, 0x0A, 0xFF in order with Rd_Data[43:28]=0x1234. State=0 after the 3rd pop.
- DEPTH=16: Arm plus 16 consecutive samples -> State=2 the cycle after the 16th, Count=16. A 17th sample -> Overflow=1, Count stays 16, and the first popped record equals sample 1.
- In DRAIN with Count=2, Rd_Ready=0 for 5 cycles -> Rd_Valid=1, Rd_Data unchanged, Count=2. Then Rd_Ready=1 for 2 cycles -> Count=0, State=0.
- Arm, 4 samples, then Reset=1 in the same cycle as Stop -> next cycle State=0, Count=0, Rd_Valid=0. A following Arm starts cleanly with Count=0.
- With TRACE_CHANGE_ONLY_EN: 4 identical samples (ALU_Out=0x33), then 1 sample with ALU_Out=0x34, then Stop -> Count=2; reads return 0x33 then 0x34. Without the macro the same stimulus gives Count=5.
